// File: rtl/tft_arb_pkg.sv
// rtl/tft_arb_pkg.sv - shared types and constants for the TFT bus arbiter and its drawers
// Contents:
//   arb_state_t          arbiter FSM state (IDLE=0, START=1, OWN=2, DRAIN=3)
//   TFT_CMD_CASET/PASET/RAMWR  TFT window / memory-write command bytes used by the drawers
//   WDT_CYCLES_DEFAULT   default session length limit for the optional watchdog
package tft_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        OWN   = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    localparam logic [7:0] TFT_CMD_CASET = 8'h2A;
    localparam logic [7:0] TFT_CMD_PASET = 8'h2B;
    localparam logic [7:0] TFT_CMD_RAMWR = 8'h2C;

    localparam int unsigned WDT_CYCLES_DEFAULT = 1048576;

endpackage

// File: rtl/tft_arbiter_rr_picker.sv
// rtl/tft_arbiter_rr_picker.sv - combinational round-robin search over the drawer requests
// Ports:
//   req     in   N_REQ  level request per drawer
//   rr_ptr  in   IDX_W  index of the last owner; search starts one above it
//   found   out  1      at least one request is set
//   index   out  IDX_W  first set request at or after rr_ptr+1, wrapping
module rr_picker #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] w_cand;

    // Walk from the farthest candidate back to the nearest so the nearest
    // set bit after rr_ptr is the one left in index.
    always_comb begin
        found  = 1'b0;
        index  = '0;
        w_cand = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            if (req[w_cand]) begin
                found = 1'b1;
                index = w_cand;
            end
        end
    end

endmodule

// File: rtl/tft_arbiter.sv
// rtl/tft_arbiter.sv - session-level round-robin arbiter sharing one TFT byte port between drawers
// Optional feature macro: TFT_ARBITER_WATCHDOG_EN (session length watchdog, limit WDT_CYCLES).
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   req               level request per drawer, held until its done pulse
//   done              one-cycle pulse to the owner when its session ends
//   drawer_enable     enable per drawer, combinational from state
//   drawer_busy       busy per drawer
//   drawer_dc/data/transmit  byte stream per drawer (data: drawer i at [8i+7:8i])
//   tft_busy          busy from the TFT SPI driver, fanned out to drawers unchanged
//   tft_dc/data/transmit     owner's byte stream, zero latency
//   grant_id          current or last owner
//   arb_busy          high whenever the FSM is not IDLE
//   wdt_fault         one-cycle pulse on a watchdog abort
module tft_arbiter
    import tft_arb_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int WDT_CYCLES = WDT_CYCLES_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    output logic [N_REQ-1:0]           done,
    output logic [N_REQ-1:0]           drawer_enable,
    input  logic [N_REQ-1:0]           drawer_busy,
    input  logic [N_REQ-1:0]           drawer_dc,
    input  logic [8*N_REQ-1:0]         drawer_data,
    input  logic [N_REQ-1:0]           drawer_transmit,
    input  logic                       tft_busy,
    output logic                       tft_dc,
    output logic [7:0]                 tft_data,
    output logic                       tft_transmit,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       arb_busy,
    output logic                       wdt_fault
);

    localparam int IDX_W = $clog2(N_REQ);

    if (WDT_CYCLES < 2) begin : g_bad_wdt_cycles
        $error("tft_arbiter: WDT_CYCLES must be at least 2");
    end

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [N_REQ-1:0] r_done;
    logic             r_wdt_fault;

    logic             w_found;
    logic [IDX_W-1:0] w_pick;
    logic             w_owner_busy;
    logic             w_wdt_hit;
    logic [7:0]       w_data_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_data
        assign w_data_arr[g] = drawer_data[8*g +: 8];
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .found  (w_found),
        .index  (w_pick)
    );

    assign w_owner_busy = drawer_busy[r_owner];

`ifdef TFT_ARBITER_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES);

    logic [WDT_W-1:0] r_wdt_cnt;

    // Held at zero outside START/OWN, so it is zero on every entry to START.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdt_cnt <= '0;
        end else if (r_state == START || r_state == OWN) begin
            r_wdt_cnt <= r_wdt_cnt + 1'b1;
        end else begin
            r_wdt_cnt <= '0;
        end
    end

    assign w_wdt_hit = (r_state == START || r_state == OWN) &&
                       (r_wdt_cnt == WDT_W'(WDT_CYCLES - 1));
`else
    assign w_wdt_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= IDX_W'(N_REQ - 1);
            r_done      <= '0;
            r_wdt_fault <= 1'b0;
        end else begin
            r_done      <= '0;
            r_wdt_fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_owner  <= w_pick;
                        r_rr_ptr <= w_pick;
                        r_state  <= START;
                    end
                end
                START: begin
                    if (w_wdt_hit) begin
                        r_done[r_owner] <= 1'b1;
                        r_wdt_fault     <= 1'b1;
                        r_state         <= DRAIN;
                    end else if (w_owner_busy) begin
                        r_state <= OWN;
                    end
                end
                OWN: begin
                    if (w_wdt_hit) begin
                        r_done[r_owner] <= 1'b1;
                        r_wdt_fault     <= 1'b1;
                        r_state         <= DRAIN;
                    end else if (!w_owner_busy) begin
                        r_done[r_owner] <= 1'b1;
                        r_state         <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Let the last byte leave the SPI driver before the next grant.
                    if (!tft_busy && !tft_transmit) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // In OWN the enable follows busy so it falls in the cycle busy falls and
    // the drawer never sees enable with busy low, i.e. it cannot restart.
    always_comb begin
        drawer_enable = '0;
        case (r_state)
            START:   drawer_enable[r_owner] = !w_wdt_hit;
            OWN:     drawer_enable[r_owner] = w_owner_busy && !w_wdt_hit;
            default: drawer_enable = '0;
        endcase
    end

    always_comb begin
        tft_dc       = 1'b0;
        tft_data     = 8'h00;
        tft_transmit = 1'b0;
        if (r_state != IDLE) begin
            tft_dc       = drawer_dc[r_owner];
            tft_data     = w_data_arr[r_owner];
            tft_transmit = drawer_transmit[r_owner];
        end
    end

    assign done      = r_done;
    assign grant_id  = r_owner;
    assign arb_busy  = (r_state != IDLE);
    assign wdt_fault = r_wdt_fault;

endmodule

// File: tb/tb_tft_arbiter.sv
// tb/tb_tft_arbiter.sv - directed self-checking bench for tft_arbiter with drawer and SPI driver models
module tb_tft_arbiter;
    import tft_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  done;
    logic [2:0]  drawer_enable;
    logic [2:0]  drawer_busy;
    logic [2:0]  drawer_dc;
    logic [23:0] drawer_data;
    logic [2:0]  drawer_transmit;
    logic        tft_busy;
    logic        tft_dc;
    logic [7:0]  tft_data;
    logic        tft_transmit;
    logic [1:0]  grant_id;
    logic        arb_busy;
    logic        wdt_fault;

    int n_tests = 0;
    int n_fail  = 0;

    int   lat    [3];
    int   nbytes [3];
    int   ds     [3];
    int   dly    [3];
    int   cnt    [3];
    logic [2:0] d_tx;
    logic       noise_on;
    logic       noise2;
    int         tcnt;

    tft_arbiter #(.N_REQ(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .done            (done),
        .drawer_enable   (drawer_enable),
        .drawer_busy     (drawer_busy),
        .drawer_dc       (drawer_dc),
        .drawer_data     (drawer_data),
        .drawer_transmit (drawer_transmit),
        .tft_busy        (tft_busy),
        .tft_dc          (tft_dc),
        .tft_data        (tft_data),
        .tft_transmit    (tft_transmit),
        .grant_id        (grant_id),
        .arb_busy        (arb_busy),
        .wdt_fault       (wdt_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_byte(input int d, input int k);
        if (k == 0)  return TFT_CMD_CASET;
        if (k == 5)  return TFT_CMD_PASET;
        if (k == 10) return TFT_CMD_RAMWR;
        return 8'(k + 40 * d);
    endfunction

    function automatic logic exp_dc(input int k);
        return !(k == 0 || k == 5 || k == 10);
    endfunction

    // Drawer models: wait lat cycles after enable, raise busy, send nbytes
    // bytes one at a time whenever the SPI driver is idle, then drop busy.
    always @(posedge clk) begin
        if (rst) begin
            drawer_busy <= '0;
            d_tx        <= '0;
            drawer_dc   <= '0;
            drawer_data <= '0;
            for (int i = 0; i < 3; i++) begin
                ds[i]  <= 0;
                dly[i] <= 0;
                cnt[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                case (ds[i])
                    0: if (drawer_enable[i]) begin
                        if (lat[i] == 0) begin
                            drawer_busy[i] <= 1'b1;
                            ds[i]          <= 2;
                        end else begin
                            dly[i] <= lat[i] - 1;
                            ds[i]  <= 1;
                        end
                    end
                    1: if (dly[i] == 0) begin
                        drawer_busy[i] <= 1'b1;
                        ds[i]          <= 2;
                    end else begin
                        dly[i] <= dly[i] - 1;
                    end
                    default: if (d_tx[i]) begin
                        d_tx[i] <= 1'b0;
                        if (cnt[i] == nbytes[i]) begin
                            drawer_busy[i] <= 1'b0;
                            ds[i]          <= 0;
                            cnt[i]         <= 0;
                        end
                    end else if (!tft_busy) begin
                        d_tx[i]             <= 1'b1;
                        drawer_data[8*i +: 8] <= exp_byte(i, cnt[i]);
                        drawer_dc[i]        <= exp_dc(cnt[i]);
                        cnt[i]              <= cnt[i] + 1;
                    end
                endcase
            end
        end
    end

    always @(posedge clk) noise2 <= noise_on & ~noise2;
    assign drawer_transmit = d_tx | {noise2, noise2, 1'b0};

    // SPI driver model: busy for two cycles after each accepted byte.
    always @(posedge clk) begin
        if (rst)               tcnt <= 0;
        else if (tft_transmit) tcnt <= 2;
        else if (tcnt != 0)    tcnt <= tcnt - 1;
    end
    assign tft_busy = (tcnt != 0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Follows one session from its START cycle to the IDLE cycle after DRAIN.
    task automatic run_session(input int owner, input int nb, input bit drop);
        int  nsent = 0;
        int  bad   = 0;
        int  dones = 0;
        int  viol  = 0;
        int  drain_bad = 0;
        bit  done_seen = 0;
        bit  busy_seen = 0;
        bit  prev_drain = 0;
        bit  prev_tbusy = 0;
        check($sformatf("grant_%0d", owner), 32'(grant_id), 32'(owner));
        for (int cyc = 0; cyc < 15000; cyc++) begin
            if (prev_drain && prev_tbusy && arb_busy !== 1'b1) drain_bad++;
            if (tft_transmit !== drawer_transmit[owner]) viol++;
            if (tft_transmit === 1'b1) begin
                if (tft_data !== exp_byte(owner, nsent) || tft_dc !== exp_dc(nsent)) bad++;
                nsent++;
            end
            if (drawer_busy[owner]) busy_seen = 1;
            if (busy_seen && !done_seen && drawer_enable[owner] && !drawer_busy[owner]) viol++;
            if ((drawer_enable & ~(3'b001 << owner)) != 3'b000) viol++;
            if (done != 3'b000) begin
                if (done === (3'b001 << owner) && !drawer_enable[owner]) dones++;
                else viol++;
                if (drop) req = 3'b000;
                done_seen = 1;
            end
            if (done_seen && !arb_busy) break;
            prev_drain = done_seen;
            prev_tbusy = tft_busy;
            tick();
        end
        check("session_end", {30'd0, done_seen, arb_busy}, 32'h2);
        check("byte_count", 32'(nsent), 32'(nb));
        check("byte_mismatch", 32'(bad), 32'd0);
        check("done_pulses", 32'(dones), 32'd1);
        check("protocol_viol", 32'(viol), 32'd0);
        check("drain_wait", 32'(drain_bad), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        req = 3'b000;
        noise_on = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lat[i]    = 0;
            nbytes[i] = 13;
        end
        tick();
        tick();

        // Reset state
        check("rst_enable", 32'(drawer_enable), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tx", 32'(tft_transmit), 32'd0);
        check("rst_data", 32'(tft_data), 32'd0);
        check("rst_dc", 32'(tft_dc), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_arb_busy", 32'(arb_busy), 32'd0);
        check("rst_wdt", 32'(wdt_fault), 32'd0);
        rst = 1'b0;

        // Single long session from drawer 1
        nbytes[1] = 1463;
        req = 3'b010;
        tick();
        check("b_enable", 32'(drawer_enable), 32'h2);
        run_session(1, 1463, 1);
        tick();
        check("b_no_regrant", 32'(arb_busy), 32'd0);

        // Six round-robin sessions with all requests held
        nbytes[1] = 13;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 3'b111;
        tick();
        for (int s = 0; s < 6; s++) begin
            run_session(s % 3, 13, s == 5);
            if (s < 5) tick();
        end
        tick();
        check("c_idle", 32'(arb_busy), 32'd0);

        // Late busy: START holds with enable high and no done
        lat[0] = 5;
        req = 3'b001;
        tick();
        for (int c = 0; c < 6; c++) begin
            check("d_start_enable", 32'(drawer_enable), 32'h1);
            check("d_start_done", 32'(done), 32'd0);
            check("d_start_busy", 32'(arb_busy), 32'd1);
            tick();
        end
        run_session(0, 13, 1);
        lat[0] = 0;
        tick();

        // Non-owner transmit noise is ignored
        noise_on = 1'b1;
        req = 3'b001;
        tick();
        run_session(0, 13, 1);
        noise_on = 1'b0;
        tick();

        // Reset in the middle of a session
        nbytes[0] = 1463;
        req = 3'b001;
        tick();
        n = 0;
        for (int c = 0; c < 4000; c++) begin
            if (tft_transmit === 1'b1) n++;
            if (n == 500) break;
            tick();
        end
        check("f_reach_500", 32'(n), 32'd500);
        rst = 1'b1;
        tick();
        check("f_enable", 32'(drawer_enable), 32'd0);
        check("f_arb_busy", 32'(arb_busy), 32'd0);
        check("f_tx", 32'(tft_transmit), 32'd0);
        check("f_data", 32'(tft_data), 32'd0);
        check("f_grant", 32'(grant_id), 32'd0);
        rst = 1'b0;
        req = 3'b101;
        tick();
        check("f_regrant", 32'(grant_id), 32'd0);
        check("f_regrant_en", 32'(drawer_enable), 32'h1);
        req = 3'b000;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tft_arbiter.md
Name: tft_arbiter

Overview:
- Shares the single TFT byte interface (dc / data / transmit / busy) between N drawer blocks: maze renderer, player sprite, score overlay.
- Each drawer runs on an enable/busy handshake. While enabled and idle, a drawer starts a full window+pixel session and holds busy until the session ends.
- The arbiter grants whole sessions round-robin and gates each drawer's enable so a drawer cannot re-trigger itself.
- It muxes the owner's byte stream to the TFT SPI driver with zero added latency.

Parameters:
- N_REQ, 3, number of drawer requesters (index 0 = maze, 1 = player, 2 = overlay).
- WDT_CYCLES, 1048576, session length limit in clk cycles (used only with the watchdog feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  N_REQ  level request per drawer; must be held until its done pulse.
- done  out  N_REQ  one-cycle pulse to the owner when its session ends.
- drawer_enable  out  N_REQ  enable to each drawer; combinational from state.
- drawer_busy  in  N_REQ  busy from each drawer.
- drawer_dc  in  N_REQ  dc from each drawer.
- drawer_data  in  8*N_REQ  data from each drawer; drawer i occupies bits [8i+7:8i].
- drawer_transmit  in  N_REQ  transmit strobe from each drawer.
- tft_busy  in  1  busy from the TFT SPI driver; fanned out unchanged to all drawers.
- tft_dc  out  1  muxed dc.
- tft_data  out  8  muxed data.
- tft_transmit  out  1  muxed transmit strobe.
- grant_id  out  $clog2(N_REQ)  current or last owner index.
- arb_busy  out  1  high in any state other than IDLE.
- wdt_fault  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (sync, rst=1):
  - state=IDLE; rr_ptr=N_REQ-1, so requester 0 wins first.
  - All outputs 0, grant_id=0.
  - Reset mid-session drops every enable on the next edge; the TFT mux outputs 0 immediately after that edge.
- States: IDLE, START, OWN, DRAIN.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from rr_ptr+1 (wrapping).
  - Register owner=grant_id and rr_ptr=owner, then go to START. Grant appears one cycle after req is sampled.
- START:
  - drawer_enable[owner]=1.
  - When drawer_busy[owner]=1, go to OWN. Nominal: busy is seen 1 cycle after enable rises.
- OWN:
  - drawer_enable[owner]=drawer_busy[owner], combinational. Enable therefore drops in the same cycle busy falls, and the drawer cannot restart a session.
  - When busy=0, go to DRAIN and register done[owner]=1 for exactly one cycle.
- DRAIN:
  - All enables 0.
  - Wait until tft_busy=0 and tft_transmit=0, then go to IDLE.
  - Gap between sessions is at least 1 cycle.
- Mux:
  - In START, OWN and DRAIN, {tft_dc, tft_data, tft_transmit} = owner's inputs, combinational and 0 latency.
  - In IDLE all three are 0.
  - Strobes from non-owners are ignored.
- Non-owner enables are always 0.
- A req bit dropping while its drawer owns the bus has no effect; the session runs to busy=0.
- Simultaneous requests: round-robin, so no requester waits more than N_REQ-1 sessions.
- A single requester held high is re-granted after each DRAIN with no starvation check.
- done is never asserted in the same cycle as that drawer's enable.

Optional Feature:
- Macro: TFT_ARBITER_WATCHDOG_EN.
- When defined:
  - A counter clears on entry to START and increments in START and OWN.
  - When it reaches WDT_CYCLES-1, force drawer_enable[owner]=0, go to DRAIN and pulse wdt_fault and done[owner].
  - The aborted drawer keeps its internal busy state and resumes from its stalled point on its next grant.
- When undefined: no counter is built, wdt_fault is tied 0 and sessions are unbounded.

Decomposition:
- Package tft_arb_pkg holds:
  - the state enum (IDLE=0, START=1, OWN=2, DRAIN=3);
  - TFT command constants CASET=8'h2A, PASET=8'h2B, RAMWR=8'h2C, shared with the drawers;
  - the default WDT_CYCLES.
- Sub-module rr_picker: combinational; inputs req and rr_ptr; outputs found and index.

Test Plan:
- Reset then req=3'b010, with a model drawer that needs 11 command bytes plus 1452 pixel bytes:
  - drawer_enable[1] rises 1 cycle after req;
  - the tft port sees 0x2A, ..., 0x2C followed by 1452 bytes;
  - done[1] pulses once;
  - enable is never high in a cycle with busy=0 after OWN is entered.
- req=3'b111 held for 6 sessions:
  - grant order 0,1,2,0,1,2;
  - no overlap of tft_transmit sources;
  - DRAIN waits for tft_busy=0.
- Non-owner drawer pulses drawer_transmit while drawer 0 owns the bus -> tft_transmit shows only owner pulses; byte count is unchanged.
- rst asserted mid-OWN at byte 500 -> all enables 0 and state IDLE next cycle; the next grant goes to requester 0.
- TFT_ARBITER_WATCHDOG_EN with WDT_CYCLES=64 and a drawer whose busy stays 1 -> wdt_fault and done pulse on cycle 64 after START entry; the next requester is then granted.
- The drawer's busy rises 5 cycles late -> state stays in START with enable=1 and no done until busy rises and falls.
